// File: rtl/seg7_pkg.sv
// ============================================================================
// Module   : seg7_pkg
// Purpose  : Shared 7-segment codes (abcdefg, active-high) and scan FSM states.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_A     = 7'b1110111;
  localparam logic [6:0] SEG_B     = 7'b0011111;
  localparam logic [6:0] SEG_C     = 7'b1001110;
  localparam logic [6:0] SEG_D     = 7'b0111101;
  localparam logic [6:0] SEG_E     = 7'b1001111;
  localparam logic [6:0] SEG_F     = 7'b1000111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/seg7_hex_decoder.sv
// ============================================================================
// Module   : seg7_hex_decoder
// Purpose  : Combinational hex nibble to 7-segment (abcdefg) decode.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_nib)
      4'h0: o_seg = SEG_0;
      4'h1: o_seg = SEG_1;
      4'h2: o_seg = SEG_2;
      4'h3: o_seg = SEG_3;
      4'h4: o_seg = SEG_4;
      4'h5: o_seg = SEG_5;
      4'h6: o_seg = SEG_6;
      4'h7: o_seg = SEG_7;
      4'h8: o_seg = SEG_8;
      4'h9: o_seg = SEG_9;
      4'hA: o_seg = SEG_A;
      4'hB: o_seg = SEG_B;
      4'hC: o_seg = SEG_C;
      4'hD: o_seg = SEG_D;
      4'hE: o_seg = SEG_E;
      4'hF: o_seg = SEG_F;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/seg7_scan_ctrl.sv
// ============================================================================
// Module   : seg7_scan_ctrl
// Purpose  : N-digit time-multiplexed 7-segment scanner with shadow register.
//            Optional macro SEG7_LEADING_ZERO_BLANK_EN blanks leading zeros.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter  int NUM_DIGITS  = 4,
  parameter  int REFRESH_DIV = 1000,
  localparam int IDX_W       = $clog2(NUM_DIGITS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    nEN,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [IDX_W-1:0]        cur_idx,
  output logic                    frame_done
);

  localparam int                    PSC_W       = $clog2(REFRESH_DIV);
  localparam logic [PSC_W-1:0]      c_psc_last  = PSC_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]      c_idx_last  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] c_an_one    = NUM_DIGITS'(1);

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [4*NUM_DIGITS-1:0]   r_shadow;
  logic [PSC_W-1:0]          r_psc;
  logic [IDX_W-1:0]          r_idx;

  logic                      w_active;
  logic                      w_slot_end;
  logic [3:0]                w_nib;
  logic [6:0]                w_dec_seg;
  logic                      w_blank;
  logic [6:0]                w_digit_seg;
  logic [6:0]                w_seg_nxt;
  logic [NUM_DIGITS-1:0]     w_an_nxt;
  logic                      w_fd_nxt;

  // A disable edge must blank the outputs on that same edge, so "active"
  // requires both the SCAN state and nEN still asserted.
  assign w_active   = (r_state == SCAN) && !nEN;
  assign w_slot_end = (r_psc == c_psc_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow <= '0;
    end else if (load) begin
      r_shadow <= digits_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (!nEN) w_state_nxt = SCAN;
      SCAN:    if (nEN)  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_psc <= '0;
      r_idx <= '0;
    end else if (w_active) begin
      if (w_slot_end) begin
        r_psc <= '0;
        r_idx <= (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
      end else begin
        r_psc <= r_psc + 1'b1;
      end
    end else begin
      r_psc <= '0;
      r_idx <= '0;
    end
  end

  assign w_nib = r_shadow[{r_idx, 2'b00} +: 4];

  seg7_hex_decoder u_dec (
    .i_nib (w_nib),
    .o_seg (w_dec_seg)
  );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] w_zero;
  logic [NUM_DIGITS-1:0] w_lead_zero;

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib_zero
      assign w_zero[gi] = (r_shadow[4*gi +: 4] == 4'h0);
    end
  endgenerate

  // w_lead_zero[i]: nibble i and every more-significant nibble are zero.
  always_comb begin
    logic v_acc;
    v_acc       = 1'b1;
    w_lead_zero = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      v_acc          = v_acc & w_zero[i];
      w_lead_zero[i] = v_acc;
    end
  end

  assign w_blank = (r_idx != '0) && w_lead_zero[r_idx];
`else
  assign w_blank = 1'b0;
`endif

  assign w_digit_seg = w_blank ? SEG_BLANK : w_dec_seg;

  always_comb begin
    w_seg_nxt = SEG_BLANK;
    w_an_nxt  = '1;
    w_fd_nxt  = 1'b0;
    if (w_active) begin
      w_seg_nxt = w_digit_seg;
      w_an_nxt  = ~(c_an_one << r_idx);
      w_fd_nxt  = w_slot_end && (r_idx == c_idx_last);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg        <= SEG_BLANK;
      an         <= '1;
      cur_idx    <= '0;
      frame_done <= 1'b0;
    end else begin
      seg        <= w_seg_nxt;
      an         <= w_an_nxt;
      cur_idx    <= r_idx;
      frame_done <= w_fd_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
// ============================================================================
// Module   : tb_seg7_scan_ctrl
// Purpose  : Directed scoreboard bench for seg7_scan_ctrl (4 digits, div 4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg7_scan_ctrl;

  localparam int ND = 4;
  localparam int RD = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        nEN;
  logic        load;
  logic [15:0] digits_in;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [1:0]  cur_idx;
  logic        frame_done;

  typedef struct packed {
    logic [6:0] seg;
    logic [3:0] an;
    logic [1:0] idx;
    logic       fd;
  } exp_t;

  exp_t        sb[$];
  string       tq[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] word;
  int          kk;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) dut (
    .clk        (clk),
    .rst        (rst),
    .nEN        (nEN),
    .load       (load),
    .digits_in  (digits_in),
    .seg        (seg),
    .an         (an),
    .cur_idx    (cur_idx),
    .frame_done (frame_done)
  );

  function automatic logic [6:0] hexseg(input logic [3:0] h);
    logic [6:0] tbl [16];
    tbl = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
            7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
            7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
            7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
    return tbl[h];
  endfunction

  function automatic exp_t scan_exp(input logic [15:0] w, input int d, input logic fd);
    exp_t e;
    logic [6:0] s;
    s = hexseg(w[d*4 +: 4]);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    if (d > 0) begin
      logic z;
      z = 1'b1;
      for (int i = d; i < ND; i++) if (w[i*4 +: 4] != 4'h0) z = 1'b0;
      if (z) s = 7'b0000000;
    end
`endif
    e.seg = s;
    e.an  = ~(4'(1) << d);
    e.idx = d[1:0];
    e.fd  = fd;
    return e;
  endfunction

  function automatic exp_t blank_exp(input logic [1:0] idx);
    exp_t e;
    e.seg = 7'b0000000;
    e.an  = 4'b1111;
    e.idx = idx;
    e.fd  = 1'b0;
    return e;
  endfunction

  task automatic push(input exp_t e, input string t);
    sb.push_back(e);
    tq.push_back(t);
  endtask

  task automatic check_now();
    exp_t  e;
    exp_t  got;
    string t;
    e   = sb.pop_front();
    t   = tq.pop_front();
    got = {seg, an, cur_idx, frame_done};
    n_cmp++;
    assert (got === e) else begin
      n_bad++;
      $error("FAIL %s: observed seg=%b an=%b idx=%0d fd=%b, expected seg=%b an=%b idx=%0d fd=%b",
             t, got.seg, got.an, got.idx, got.fd, e.seg, e.an, e.idx, e.fd);
    end
  endtask

  task automatic tick_check();
    @(posedge clk);
    #1;
    check_now();
  endtask

  // kk counts scan edges since the enable edge; digit d is shown for kk in 4d+1..4d+4.
  task automatic scan_steps(input int n, input string t);
    for (int s = 0; s < n; s++) begin
      kk++;
      push(scan_exp(word, ((kk - 1) / RD) % ND, (kk % (RD * ND)) == 0), t);
      tick_check();
    end
  endtask

  task automatic load_in_scan(input logic [15:0] nw);
    load      = 1'b1;
    digits_in = nw;
    scan_steps(1, "load_edge_old_word");
    load      = 1'b0;
    word      = nw;
  endtask

  task automatic idle_step(input logic [1:0] idx, input string t);
    push(blank_exp(idx), t);
    tick_check();
  endtask

  initial begin
    rst = 1'b1; nEN = 1'b1; load = 1'b0; digits_in = '0;
    word = '0; kk = 0;
    repeat (2) @(posedge clk);
    #1;
    push(blank_exp(2'd0), "reset_state");
    check_now();
    rst = 1'b0;
    idle_step(2'd0, "idle_hold");

    load = 1'b1; digits_in = 16'h1294;
    idle_step(2'd0, "load_in_idle");
    load = 1'b0; word = 16'h1294;
    nEN = 1'b0;
    idle_step(2'd0, "enable_edge");
    kk = 0;
    scan_steps(41, "basic_scan");

    nEN = 1'b1;
    idle_step(2'd2, "disable_at_idx2");
    idle_step(2'd0, "idle_after_disable");
    nEN = 1'b0;
    idle_step(2'd0, "reenable_edge");
    kk = 0;
    scan_steps(2, "restart_digit0");

    load_in_scan(16'hABCD);
    scan_steps(28, "after_load");

    nEN = 1'b1;
    idle_step(2'd3, "wrap_vs_disable");
    idle_step(2'd0, "idle_after_wrap_disable");

    load = 1'b1; digits_in = 16'h0090;
    idle_step(2'd0, "load_0090");
    load = 1'b0; word = 16'h0090;
    nEN = 1'b0;
    idle_step(2'd0, "enable_0090");
    kk = 0;
    scan_steps(16, "lz_0090");
    load_in_scan(16'h0000);
    scan_steps(18, "lz_0000");

    #2;
    rst = 1'b1;
    #1;
    push(blank_exp(2'd0), "async_reset_mid_scan");
    check_now();
    idle_step(2'd0, "reset_held");
    rst = 1'b0; word = 16'h0000;
    idle_step(2'd0, "post_reset_enable");
    kk = 0;
    scan_steps(4, "post_reset_scan");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
